// File: rtl/frame_draw_scheduler.sv
// -----------------------------------------------------------------------------
// frame_draw_scheduler
//
// Purpose:
//   Shares the single VGA plot port between three draw requesters for each
//   frame: background erase (0), wall drawer (1) and bird drawer (2). On every
//   frame tick the port is granted to each requester in order 0 -> 1 -> 2.
//   After that, update_tick pulses so the game controllers can advance their
//   positions. A collision seen at the end of a frame freezes the scheduler in
//   HALT until the player presses go.
//
// Optional feature (macro GRANT_WATCHDOG_EN):
//   When defined, a per-grant cycle counter force-releases a grant held for
//   TIMEOUT cycles without done and sets the sticky timeout_err flag.
//   When undefined, a grant is held until done and timeout_err is tied to 0.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   req[2:0]            per-requester "has work this frame" (level)
//   done[2:0]           per-requester completion pulse
//   x_in/y_in/colour_in packed per-requester pixel fields (requester i at i*W)
//   plot_in[2:0]        per-requester plot strobe
//   collision, go       game collision level, synchronised player key
//   grant[2:0]          one-hot grant (0 when nobody is granted)
//   vga_x/y/colour/plot registered mux of the granted requester
//   update_tick         one-cycle pulse after a frame has been drawn
//   restart, halted     leaving-HALT pulse, HALT indicator
//   frame_overrun       sticky: tick arrived while a frame was in progress
//   timeout_err         sticky: a grant was force-released
//
// States:
//   IDLE    | waiting for a frame tick or a queued tick
//   G_ERASE | port granted to background erase
//   G_WALL  | port granted to wall drawer
//   G_BIRD  | port granted to bird drawer
//   UPDATE  | frame drawn, update_tick high
//   HALT    | collision freeze, waiting for a go rising edge
// -----------------------------------------------------------------------------
module frame_draw_scheduler #(
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int COLOUR_W     = 3,
    parameter int FRAME_CYCLES = 833334,
    parameter int TIMEOUT      = 65535
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [2:0]            req,
    input  logic [2:0]            done,
    input  logic [3*X_W-1:0]      x_in,
    input  logic [3*Y_W-1:0]      y_in,
    input  logic [3*COLOUR_W-1:0] colour_in,
    input  logic [2:0]            plot_in,
    input  logic                  collision,
    input  logic                  go,
    output logic [2:0]            grant,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [COLOUR_W-1:0]   vga_colour,
    output logic                  vga_plot,
    output logic                  update_tick,
    output logic                  restart,
    output logic                  halted,
    output logic                  frame_overrun,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    if (FRAME_CYCLES < 4 || TIMEOUT < 2) begin : g_param_check
        $error("frame_draw_scheduler: FRAME_CYCLES must be >= 4 and TIMEOUT >= 2");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        G_ERASE = 3'd1,
        G_WALL  = 3'd2,
        G_BIRD  = 3'd3,
        UPDATE  = 3'd4,
        HALT    = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic             first;
    logic             go_q;

    logic             frame_tick;
    logic             in_grant;
    logic             cur_req;
    logic             cur_done;
    logic             skip;
    logic             wd_trip;
    logic             advance;
    state_t           next_state;
    logic [2:0]       next_grant;

    always_comb begin
        in_grant   = 1'b0;
        cur_req    = 1'b0;
        cur_done   = 1'b0;
        next_state = IDLE;
        next_grant = 3'b000;
        case (state)
            G_ERASE: begin
                in_grant   = 1'b1;
                cur_req    = req[0];
                cur_done   = done[0];
                next_state = G_WALL;
                next_grant = 3'b010;
            end
            G_WALL: begin
                in_grant   = 1'b1;
                cur_req    = req[1];
                cur_done   = done[1];
                next_state = G_BIRD;
                next_grant = 3'b100;
            end
            G_BIRD: begin
                in_grant   = 1'b1;
                cur_req    = req[2];
                cur_done   = done[2];
                next_state = UPDATE;
                next_grant = 3'b000;
            end
            default: ;
        endcase
    end

    // HALT holds the counter at 0, so no tick can be produced there.
    assign frame_tick = (cnt == CNT_LAST);
    // A requester with no work is only consulted in its first granted cycle.
    assign skip       = in_grant & first & ~cur_req;
    assign advance    = in_grant & (skip | cur_done | wd_trip);

`ifdef GRANT_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;

    // Trips in the TIMEOUT-th cycle of a grant, releasing it on the next edge.
    assign wd_trip = in_grant & (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (in_grant && !advance) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (wd_trip && !cur_done && !skip) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign wd_trip     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            pending       <= 1'b0;
            first         <= 1'b0;
            go_q          <= 1'b0;
            grant         <= 3'b000;
            update_tick   <= 1'b0;
            restart       <= 1'b0;
            halted        <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            update_tick <= 1'b0;
            restart     <= 1'b0;
            go_q        <= go;

            if (state == HALT || frame_tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Only one tick can be queued; later ones leave pending unchanged.
            if (frame_tick && state != IDLE && state != HALT) begin
                pending       <= 1'b1;
                frame_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_tick || pending) begin
                        state   <= G_ERASE;
                        grant   <= 3'b001;
                        first   <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                G_ERASE, G_WALL, G_BIRD: begin
                    first <= 1'b0;
                    if (advance) begin
                        state <= next_state;
                        grant <= next_grant;
                        first <= 1'b1;
                        if (next_state == UPDATE) begin
                            update_tick <= 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    if (collision) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                HALT: begin
                    pending <= 1'b0;
                    if (go && !go_q) begin
                        state   <= IDLE;
                        halted  <= 1'b0;
                        restart <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel fields hold their last value while nobody is granted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= |(plot_in & grant);
            if (grant[0]) begin
                vga_x      <= x_in[0 +: X_W];
                vga_y      <= y_in[0 +: Y_W];
                vga_colour <= colour_in[0 +: COLOUR_W];
            end else if (grant[1]) begin
                vga_x      <= x_in[X_W +: X_W];
                vga_y      <= y_in[Y_W +: Y_W];
                vga_colour <= colour_in[COLOUR_W +: COLOUR_W];
            end else if (grant[2]) begin
                vga_x      <= x_in[2*X_W +: X_W];
                vga_y      <= y_in[2*Y_W +: Y_W];
                vga_colour <= colour_in[2*COLOUR_W +: COLOUR_W];
            end
        end
    end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_draw_scheduler
//
// Purpose:
//   Directed bench for frame_draw_scheduler with FRAME_CYCLES=16, TIMEOUT=32.
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   sampled at the same point, well away from the next edge. Watchdog
//   expectations follow GRANT_WATCHDOG_EN.
// -----------------------------------------------------------------------------
module tb_frame_draw_scheduler;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    logic                  clk;
    logic                  resetn;
    logic [2:0]            req;
    logic [2:0]            done;
    logic [3*X_W-1:0]      x_in;
    logic [3*Y_W-1:0]      y_in;
    logic [3*COLOUR_W-1:0] colour_in;
    logic [2:0]            plot_in;
    logic                  collision;
    logic                  go;
    logic [2:0]            grant;
    logic [X_W-1:0]        vga_x;
    logic [Y_W-1:0]        vga_y;
    logic [COLOUR_W-1:0]   vga_colour;
    logic                  vga_plot;
    logic                  update_tick;
    logic                  restart;
    logic                  halted;
    logic                  frame_overrun;
    logic                  timeout_err;

    int errors = 0;
    int checks = 0;
    int plot_cnt = 0;

    frame_draw_scheduler #(
        .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W),
        .FRAME_CYCLES(16), .TIMEOUT(32)
    ) dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot_in(plot_in),
        .collision(collision), .go(go), .grant(grant),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .update_tick(update_tick), .restart(restart),
        .halted(halted), .frame_overrun(frame_overrun),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (vga_plot === 1'b1) plot_cnt++;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [2:0] g, input int max_cyc,
                              output int n);
        n = 0;
        while (grant !== g && n < max_cyc) begin
            step();
            n++;
        end
        if (grant !== g) check_val("wait_grant", 32'(grant), 32'(g));
    endtask

    initial begin
        int n;
        int p0;
        int bad;

        resetn    = 1'b0;
        req       = 3'b000;
        done      = 3'b000;
        plot_in   = 3'b000;
        collision = 1'b0;
        go        = 1'b0;
        x_in      = {8'd7, 8'd5, 8'd1};
        y_in      = {7'd11, 7'd9, 7'd2};
        colour_in = {3'b101, 3'b010, 3'b111};
        step();
        step();

        // Reset state
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_flags", {26'd0, update_tick, restart, halted,
                  frame_overrun, timeout_err, vga_plot}, 32'd0);
        check_val("rst_vga_x", 32'(vga_x), 32'd0);

        // Idle frames, nobody has work
        resetn = 1'b1;
        p0 = plot_cnt;
        wait_grant(3'b001, 40, n);
        check_val("first_tick_latency", 32'(n), 32'd16);
        step();
        check_val("skip_wall", 32'(grant), 32'b010);
        step();
        check_val("skip_bird", 32'(grant), 32'b100);
        step();
        check_val("update_pulse", {30'd0, update_tick, |grant}, 32'b10);
        n = 0;
        do begin
            step();
            n++;
        end while (update_tick !== 1'b1 && n < 40);
        check_val("update_period", 32'(n), 32'd16);
        check_val("idle_no_plot", 32'(plot_cnt - p0), 32'd0);

        // Wall plots 4 pixels
        req = 3'b111;
        wait_grant(3'b001, 40, n);
        done = 3'b001;
        step();
        check_val("erase_done_first", 32'(grant), 32'b010);
        check_val("plot_latency", 32'(vga_plot), 32'd0);
        done = 3'b000;
        plot_in = 3'b010;
        p0 = plot_cnt;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) done = 3'b010;
            step();
            check_val("wall_plot", 32'(vga_plot), 32'd1);
            if (k == 0)
                check_val("wall_pixel", {14'd0, vga_x, vga_y, vga_colour},
                          {14'd0, 8'd5, 7'd9, 3'b010});
        end
        check_val("wall_to_bird", 32'(grant), 32'b100);
        plot_in = 3'b000;
        done = 3'b100;
        step();
        check_val("bird_done_update", {29'd0, update_tick, vga_plot, |grant},
                  32'b100);
        done = 3'b000;
        step();
        check_val("x_hold", 32'(vga_x), 32'd7);
        check_val("wall_plot_count", 32'(plot_cnt - p0), 32'd4);

        // Bird overruns the frame
        check_val("no_overrun_yet", 32'(frame_overrun), 32'd0);
        wait_grant(3'b001, 40, n);
        done = 3'b001;
        step();
        done = 3'b010;
        step();
        check_val("bird_grant", 32'(grant), 32'b100);
        done = 3'b000;
        repeat (20) step();
        check_val("bird_hold", 32'(grant), 32'b100);
        done = 3'b100;
        step();
        check_val("overrun_update", {30'd0, update_tick, frame_overrun}, 32'b11);
        done = 3'b000;
        step();
        check_val("overrun_idle", 32'(grant), 32'd0);
        step();
        check_val("queued_frame", 32'(grant), 32'b001);
        done = 3'b001;
        step();
        done = 3'b010;
        step();
        done = 3'b100;
        step();
        done = 3'b000;
        check_val("queued_update", 32'(update_tick), 32'd1);
        step();
        step();
        check_val("only_one_queued", 32'(grant), 32'd0);
        step();
        check_val("only_one_queued2", 32'(grant), 32'd0);

        // Collision during wall grant
        req = 3'b000;
        wait_grant(3'b001, 40, n);
        step();
        collision = 1'b1;
        step();
        step();
        check_val("coll_update", 32'(update_tick), 32'd1);
        step();
        check_val("halt_enter", {30'd0, halted, |grant}, 32'b10);
        collision = 1'b0;
        bad = 0;
        repeat (40) begin
            step();
            if (grant !== 3'b000 || update_tick !== 1'b0) bad++;
        end
        check_val("halt_ignores_ticks", 32'(bad), 32'd0);
        check_val("halt_still", 32'(halted), 32'd1);
        go = 1'b1;
        step();
        check_val("restart_pulse", {30'd0, restart, halted}, 32'b10);
        step();
        check_val("restart_once", 32'(restart), 32'd0);
        wait_grant(3'b001, 40, n);
        check_val("restart_tick_latency", 32'(n), 32'd15);
        go = 1'b0;
        repeat (5) step();

        // Erase never signals done
        req = 3'b011;
        wait_grant(3'b001, 40, n);
        bad = 0;
        repeat (31) begin
            step();
            if (grant !== 3'b001) bad++;
        end
        check_val("grant_held", 32'(bad), 32'd0);
        step();
`ifdef GRANT_WATCHDOG_EN
        check_val("wd_release", 32'(grant), 32'b010);
        check_val("wd_err", 32'(timeout_err), 32'd1);
`else
        check_val("no_wd_hold", 32'(grant), 32'b001);
        check_val("no_wd_err", 32'(timeout_err), 32'd0);
        done = 3'b001;
        step();
        done = 3'b000;
`endif
        step();
        check_val("wall_holding", 32'(grant), 32'b010);
        check_val("overrun_sticky", 32'(frame_overrun), 32'd1);

        // Reset in the middle of a wall grant
        resetn = 1'b0;
        step();
        check_val("midrst_grant", 32'(grant), 32'd0);
        check_val("midrst_flags", {26'd0, update_tick, restart, halted,
                  frame_overrun, timeout_err, vga_plot}, 32'd0);
        resetn = 1'b1;
        req = 3'b000;
        step();
        check_val("midrst_idle", 32'(grant), 32'd0);
        wait_grant(3'b001, 40, n);
        check_val("midrst_tick_latency", 32'(n), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
